// File: rtl/clk_divider_prog_if.sv
// Control/status bundle for clk_divider_prog; o_tick_cnt exists only when
// CLKDIV_TICK_CNT_EN is defined.
interface clk_divider_prog_if #(
   parameter int WIDTH = 16
);
   logic             i_ce;
   logic             i_load;
   logic [WIDTH-1:0] i_div;
   logic             i_mode;
   logic             o_div_clk;
   logic             o_tick;
   logic             o_load_ack;
   logic [WIDTH-1:0] o_active_div;
`ifdef CLKDIV_TICK_CNT_EN
   logic [7:0]       o_tick_cnt;
`endif

   modport master (
      output i_ce, i_load, i_div, i_mode,
`ifdef CLKDIV_TICK_CNT_EN
      input  o_tick_cnt,
`endif
      input  o_div_clk, o_tick, o_load_ack, o_active_div
   );

   modport slave (
      input  i_ce, i_load, i_div, i_mode,
`ifdef CLKDIV_TICK_CNT_EN
      output o_tick_cnt,
`endif
      output o_div_clk, o_tick, o_load_ack, o_active_div
   );
endinterface

// File: rtl/clk_divider_prog.sv
// Programmable divider/tick generator with shadowed divisor/mode update.
// Optional CLKDIV_TICK_CNT_EN adds an 8-bit tick counter on o_tick_cnt.
module clk_divider_prog #(
   parameter int WIDTH     = 16,
   parameter int RESET_DIV = 50000
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   clk_divider_prog_if.slave  bus
);
   typedef enum logic {MODE_TOGGLE = 1'b0, MODE_PULSE = 1'b1} mode_e;

   localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(RESET_DIV);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] active_div_q, active_div_d;
   logic [WIDTH-1:0] pend_div_q, pend_div_d;
   mode_e            mode_q, mode_d;
   mode_e            pend_mode_q, pend_mode_d;
   logic             pend_vld_q, pend_vld_d;
   logic             div_clk_q, div_clk_d;
   logic             tick_q, tick_d;
   logic             ack_q, ack_d;
   logic             tc;

   assign tc = bus.i_ce && (cnt_q == active_div_q - WIDTH'(1));

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      cnt_d        = cnt_q;
      active_div_d = active_div_q;
      mode_d       = mode_q;
      pend_div_d   = pend_div_q;
      pend_mode_d  = pend_mode_q;
      pend_vld_d   = pend_vld_q;
      div_clk_d    = div_clk_q;
      tick_d       = 1'b0;
      ack_d        = 1'b0;

      if (tc) begin
         cnt_d  = '0;
         tick_d = 1'b1;
         if (pend_vld_q) begin
            // New settings take over at the count boundary, output restarted cleanly.
            active_div_d = pend_div_q;
            mode_d       = pend_mode_q;
            pend_vld_d   = 1'b0;
            ack_d        = 1'b1;
            div_clk_d    = (pend_mode_q == MODE_PULSE);
         end else begin
            div_clk_d = (mode_q == MODE_PULSE) ? 1'b1 : ~div_clk_q;
         end
      end else begin
         if (bus.i_ce) cnt_d = cnt_q + WIDTH'(1);
         if (mode_q == MODE_PULSE) div_clk_d = 1'b0;
      end

      // Capture after application so a load coincident with tc stays pending.
      if (bus.i_load) begin
         pend_div_d  = (bus.i_div == '0) ? WIDTH'(1) : bus.i_div;
         pend_mode_d = mode_e'(bus.i_mode);
         pend_vld_d  = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignments to avoid update-order races.
      if (!i_rst_n) begin
         cnt_q        <= '0;
         active_div_q <= RST_DIV;
         mode_q       <= MODE_TOGGLE;
         pend_div_q   <= RST_DIV;
         pend_mode_q  <= MODE_TOGGLE;
         pend_vld_q   <= 1'b0;
         div_clk_q    <= 1'b0;
         tick_q       <= 1'b0;
         ack_q        <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         active_div_q <= active_div_d;
         mode_q       <= mode_d;
         pend_div_q   <= pend_div_d;
         pend_mode_q  <= pend_mode_d;
         pend_vld_q   <= pend_vld_d;
         div_clk_q    <= div_clk_d;
         tick_q       <= tick_d;
         ack_q        <= ack_d;
      end
   end

   assign bus.o_div_clk    = div_clk_q;
   assign bus.o_tick       = tick_q;
   assign bus.o_load_ack   = ack_q;
   assign bus.o_active_div = active_div_q;

`ifdef CLKDIV_TICK_CNT_EN
   logic [7:0] tick_cnt_q, tick_cnt_d;

   always_comb begin
      tick_cnt_d = tick_cnt_q;
      if (tc && pend_vld_q) tick_cnt_d = '0;
      else if (tc)          tick_cnt_d = tick_cnt_q + 8'd1;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) tick_cnt_q <= '0;
      else          tick_cnt_q <= tick_cnt_d;
   end

   assign bus.o_tick_cnt = tick_cnt_q;
`endif
endmodule

// File: tb/tb_clk_divider_prog.sv
// Directed bench for clk_divider_prog (WIDTH=16, RESET_DIV=5); the tick counter
// scenario is compiled in when CLKDIV_TICK_CNT_EN is defined.
module tb_clk_divider_prog;
   logic clk = 1'b0;
   logic rst_n;
   int   vectors = 0;
   int   miscompares = 0;

   clk_divider_prog_if #(.WIDTH(16)) bus ();

   clk_divider_prog #(.WIDTH(16), .RESET_DIV(5)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; bus.i_ce = 1'b1; bus.i_load = 1'b0; bus.i_div = '0; bus.i_mode = 1'b0;
      step(); step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; bus.i_ce = 1'b1; bus.i_load = 1'b1; bus.i_div = 16'd9; bus.i_mode = 1'b1;
      step(); step();
      vectors++; if (bus.o_div_clk !== 1'b0) begin miscompares++; $display("FAIL reset_div_clk: got %b want 0", bus.o_div_clk); end
      vectors++; if (bus.o_tick !== 1'b0) begin miscompares++; $display("FAIL reset_tick: got %b want 0", bus.o_tick); end
      vectors++; if (bus.o_load_ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack: got %b want 0", bus.o_load_ack); end
      vectors++; if (bus.o_active_div !== 16'd5) begin miscompares++; $display("FAIL reset_active: got %0d want 5", bus.o_active_div); end
      bus.i_load = 1'b0; rst_n = 1'b1;
   endtask

   task automatic test_toggle_mode();
      do_reset();
      for (int k = 1; k <= 20; k++) begin
         step();
         vectors++; if (bus.o_tick !== (k % 5 == 0)) begin miscompares++; $display("FAIL toggle_tick[%0d]: got %b want %b", k, bus.o_tick, (k % 5 == 0)); end
         vectors++; if (bus.o_div_clk !== ((k / 5) % 2 == 1)) begin miscompares++; $display("FAIL toggle_div_clk[%0d]: got %b want %b", k, bus.o_div_clk, ((k / 5) % 2 == 1)); end
      end
      vectors++; if (bus.o_active_div !== 16'd5) begin miscompares++; $display("FAIL toggle_active: got %0d want 5", bus.o_active_div); end
   endtask

   task automatic test_load_mid();
      do_reset();
      step();                                   // counter = 1
      bus.i_load = 1'b1; bus.i_div = 16'd3; bus.i_mode = 1'b1;
      step();
      bus.i_load = 1'b0;
      step(); step();                           // edge 4
      vectors++; if (bus.o_active_div !== 16'd5) begin miscompares++; $display("FAIL load_mid_pre_active: got %0d want 5", bus.o_active_div); end
      vectors++; if (bus.o_load_ack !== 1'b0) begin miscompares++; $display("FAIL load_mid_pre_ack: got %b want 0", bus.o_load_ack); end
      step();                                   // edge 5: tc applies
      vectors++; if (bus.o_load_ack !== 1'b1) begin miscompares++; $display("FAIL load_mid_ack: got %b want 1", bus.o_load_ack); end
      vectors++; if (bus.o_active_div !== 16'd3) begin miscompares++; $display("FAIL load_mid_active: got %0d want 3", bus.o_active_div); end
      vectors++; if (bus.o_div_clk !== 1'b1) begin miscompares++; $display("FAIL load_mid_strobe: got %b want 1", bus.o_div_clk); end
      for (int j = 1; j <= 9; j++) begin
         step();
         vectors++; if (bus.o_div_clk !== (j % 3 == 0)) begin miscompares++; $display("FAIL pulse_div_clk[%0d]: got %b want %b", j, bus.o_div_clk, (j % 3 == 0)); end
         vectors++; if (bus.o_load_ack !== 1'b0) begin miscompares++; $display("FAIL pulse_ack[%0d]: got %b want 0", j, bus.o_load_ack); end
      end
   endtask

   task automatic test_last_write();
      do_reset();
      bus.i_load = 1'b1; bus.i_div = 16'd8; bus.i_mode = 1'b0;
      step();
      bus.i_div = 16'd2;
      step();
      bus.i_load = 1'b0;
      step(); step();                           // edge 4
      vectors++; if (bus.o_load_ack !== 1'b0) begin miscompares++; $display("FAIL last_write_early_ack: got %b want 0", bus.o_load_ack); end
      step();                                   // edge 5
      vectors++; if (bus.o_load_ack !== 1'b1) begin miscompares++; $display("FAIL last_write_ack: got %b want 1", bus.o_load_ack); end
      vectors++; if (bus.o_active_div !== 16'd2) begin miscompares++; $display("FAIL last_write_active: got %0d want 2", bus.o_active_div); end
      vectors++; if (bus.o_div_clk !== 1'b0) begin miscompares++; $display("FAIL last_write_level: got %b want 0", bus.o_div_clk); end
      step(); step();                           // edge 7: next tc with div 2
      vectors++; if (bus.o_tick !== 1'b1) begin miscompares++; $display("FAIL div2_tick: got %b want 1", bus.o_tick); end
      vectors++; if (bus.o_div_clk !== 1'b1) begin miscompares++; $display("FAIL div2_toggle: got %b want 1", bus.o_div_clk); end
      vectors++; if (bus.o_load_ack !== 1'b0) begin miscompares++; $display("FAIL last_write_second_ack: got %b want 0", bus.o_load_ack); end
      bus.i_load = 1'b1; bus.i_div = 16'd0;
      step();
      bus.i_load = 1'b0;
      step();                                   // edge 9: tc applies clamped divisor
      vectors++; if (bus.o_active_div !== 16'd1) begin miscompares++; $display("FAIL zero_clamp_active: got %0d want 1", bus.o_active_div); end
      vectors++; if (bus.o_load_ack !== 1'b1) begin miscompares++; $display("FAIL zero_clamp_ack: got %b want 1", bus.o_load_ack); end
   endtask

   task automatic test_coincident();
      do_reset();
      bus.i_load = 1'b1; bus.i_div = 16'd4; bus.i_mode = 1'b0;
      step();
      bus.i_load = 1'b0;
      step(); step(); step();                   // edge 4
      bus.i_load = 1'b1; bus.i_div = 16'd2;
      step();                                   // edge 5: tc with load
      bus.i_load = 1'b0;
      vectors++; if (bus.o_load_ack !== 1'b1) begin miscompares++; $display("FAIL coinc_first_ack: got %b want 1", bus.o_load_ack); end
      vectors++; if (bus.o_active_div !== 16'd4) begin miscompares++; $display("FAIL coinc_first_active: got %0d want 4", bus.o_active_div); end
      step(); step(); step();                   // edge 8
      vectors++; if (bus.o_load_ack !== 1'b0) begin miscompares++; $display("FAIL coinc_gap_ack: got %b want 0", bus.o_load_ack); end
      vectors++; if (bus.o_active_div !== 16'd4) begin miscompares++; $display("FAIL coinc_gap_active: got %0d want 4", bus.o_active_div); end
      step();                                   // edge 9
      vectors++; if (bus.o_load_ack !== 1'b1) begin miscompares++; $display("FAIL coinc_second_ack: got %b want 1", bus.o_load_ack); end
      vectors++; if (bus.o_active_div !== 16'd2) begin miscompares++; $display("FAIL coinc_second_active: got %0d want 2", bus.o_active_div); end
   endtask

   task automatic test_ce_toggle();
      do_reset();
      bus.i_load = 1'b1; bus.i_div = 16'd4; bus.i_mode = 1'b0;
      step();
      bus.i_load = 1'b0;
      step(); step(); step(); step();           // edge 5: divisor 4 applied, counter 0
      vectors++; if (bus.o_load_ack !== 1'b1) begin miscompares++; $display("FAIL ce_setup_ack: got %b want 1", bus.o_load_ack); end
      for (int r = 1; r <= 16; r++) begin
         bus.i_ce = (r % 2 == 1);
         step();
         vectors++; if (bus.o_tick !== (r == 7 || r == 15)) begin miscompares++; $display("FAIL ce_tick[%0d]: got %b want %b", r, bus.o_tick, (r == 7 || r == 15)); end
         vectors++; if (bus.o_div_clk !== (r >= 7 && r < 15)) begin miscompares++; $display("FAIL ce_level[%0d]: got %b want %b", r, bus.o_div_clk, (r >= 7 && r < 15)); end
      end
      bus.i_ce = 1'b1;
   endtask

   task automatic test_div_one();
      do_reset();
      bus.i_load = 1'b1; bus.i_div = 16'd1; bus.i_mode = 1'b1;
      step();
      bus.i_load = 1'b0;
      step(); step(); step(); step();           // edge 5: applied
      for (int j = 0; j < 5; j++) begin
         step();
         vectors++; if (bus.o_div_clk !== 1'b1) begin miscompares++; $display("FAIL div1_high[%0d]: got %b want 1", j, bus.o_div_clk); end
         vectors++; if (bus.o_tick !== 1'b1) begin miscompares++; $display("FAIL div1_tick[%0d]: got %b want 1", j, bus.o_tick); end
      end
      bus.i_ce = 1'b0;
      step();
      vectors++; if (bus.o_div_clk !== 1'b0) begin miscompares++; $display("FAIL div1_ce_off_level: got %b want 0", bus.o_div_clk); end
      vectors++; if (bus.o_tick !== 1'b0) begin miscompares++; $display("FAIL div1_ce_off_tick: got %b want 0", bus.o_tick); end
      bus.i_ce = 1'b1;
   endtask

   task automatic test_reset_pending();
      do_reset();
      bus.i_load = 1'b1; bus.i_div = 16'd3; bus.i_mode = 1'b1;
      step();
      bus.i_load = 1'b0;
      step(); step();                           // edge 3, load still pending
      rst_n = 1'b0;
      step();
      vectors++; if (bus.o_active_div !== 16'd5) begin miscompares++; $display("FAIL rst_pend_active: got %0d want 5", bus.o_active_div); end
      vectors++; if (bus.o_load_ack !== 1'b0) begin miscompares++; $display("FAIL rst_pend_ack: got %b want 0", bus.o_load_ack); end
      rst_n = 1'b1;
      step(); step(); step(); step();
      vectors++; if (bus.o_tick !== 1'b0) begin miscompares++; $display("FAIL rst_pend_early_tick: got %b want 0", bus.o_tick); end
      step();                                   // edge 5 after release
      vectors++; if (bus.o_tick !== 1'b1) begin miscompares++; $display("FAIL rst_pend_tick: got %b want 1", bus.o_tick); end
      vectors++; if (bus.o_load_ack !== 1'b0) begin miscompares++; $display("FAIL rst_pend_no_ack: got %b want 0", bus.o_load_ack); end
      vectors++; if (bus.o_active_div !== 16'd5) begin miscompares++; $display("FAIL rst_pend_kept_div: got %0d want 5", bus.o_active_div); end
      vectors++; if (bus.o_div_clk !== 1'b1) begin miscompares++; $display("FAIL rst_pend_toggle: got %b want 1", bus.o_div_clk); end
   endtask

`ifdef CLKDIV_TICK_CNT_EN
   task automatic test_tick_cnt();
      do_reset();
      step(); step(); step(); step(); step();   // edge 5: first tick
      vectors++; if (bus.o_tick_cnt !== 8'd1) begin miscompares++; $display("FAIL tcnt_first: got %0d want 1", bus.o_tick_cnt); end
      bus.i_load = 1'b1; bus.i_div = 16'd1; bus.i_mode = 1'b0;
      step();
      bus.i_load = 1'b0;
      step(); step(); step();                   // edge 9
      vectors++; if (bus.o_tick_cnt !== 8'd1) begin miscompares++; $display("FAIL tcnt_hold: got %0d want 1", bus.o_tick_cnt); end
      step();                                   // edge 10: application clears
      vectors++; if (bus.o_tick_cnt !== 8'd0) begin miscompares++; $display("FAIL tcnt_clear: got %0d want 0", bus.o_tick_cnt); end
      for (int j = 0; j < 255; j++) step();
      vectors++; if (bus.o_tick_cnt !== 8'd255) begin miscompares++; $display("FAIL tcnt_255: got %0d want 255", bus.o_tick_cnt); end
      step();
      vectors++; if (bus.o_tick_cnt !== 8'd0) begin miscompares++; $display("FAIL tcnt_wrap: got %0d want 0", bus.o_tick_cnt); end
   endtask
`endif

   initial begin
      rst_n = 1'b0; bus.i_ce = 1'b0; bus.i_load = 1'b0; bus.i_div = '0; bus.i_mode = 1'b0;
      test_reset();
      test_toggle_mode();
      test_load_mid();
      test_last_write();
      test_coincident();
      test_ce_toggle();
      test_div_one();
      test_reset_pending();
`ifdef CLKDIV_TICK_CNT_EN
      test_tick_cnt();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
